// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronizes the release of an asynchronous reset, holds the
// downstream reset for a fixed time, and generates fixed-length software resets.
module reset_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int HOLD_CYCLES   = 16,
    parameter int SW_RST_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             sw_rst_req,
    output logic             rst_out_n,
    output logic             rst_done,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_cnt
);

    // state  | meaning
    // ASSERT | reset held, waiting for synchronized release
    // HOLD   | counting HOLD_CYCLES before releasing rst_out_n
    // RUN    | reset released, sequence complete
    // SWRST  | software reset pulse of SW_RST_CYCLES
    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_SWRST  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_RST_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_rel;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rst_out_n_q, rst_out_n_d;
    logic                   rst_done_q, rst_done_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign sync_rel = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rst_out_n_d = rst_out_n_q;
        rst_done_d  = rst_done_q;
        case (state_q)
            ST_ASSERT: begin
                cnt_d       = '0;
                rst_out_n_d = 1'b0;
                rst_done_d  = 1'b0;
                if (sync_rel) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d     = ST_RUN;
                    cnt_d       = '0;
                    rst_out_n_d = 1'b1;
                    rst_done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (sw_rst_req) begin
                    state_d     = ST_SWRST;
                    cnt_d       = '0;
                    rst_out_n_d = 1'b0;
                    rst_done_d  = 1'b0;
                end
            end
            ST_SWRST: begin
                // Requests are ignored here so a held request cannot stretch the pulse.
                if (cnt_q == SW_LAST) begin
                    state_d     = ST_RUN;
                    cnt_d       = '0;
                    rst_out_n_d = 1'b1;
                    rst_done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = ST_ASSERT;
                cnt_d       = '0;
                rst_out_n_d = 1'b0;
                rst_done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            sync_q      <= '0;
            state_q     <= ST_ASSERT;
            cnt_q       <= '0;
            rst_out_n_q <= 1'b0;
            rst_done_q  <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rst_out_n_q <= rst_out_n_d;
            rst_done_q  <= rst_done_d;
        end
    end

    assign rst_out_n = rst_out_n_q;
    assign rst_done  = rst_done_q;
    assign state     = state_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a short-hold,
// deep-synchronizer instance sharing clock and arst.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       arst;
    logic       sw_rst_req;
    logic       rst_out_n, rst_done;
    logic [1:0] state;
    logic [7:0] cycle_cnt;
    logic       rst2_n, done2;
    logic [1:0] state2;
    logic [7:0] cnt2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reset_sequencer u_dut (
        .clk        (clk),
        .arst       (arst),
        .sw_rst_req (sw_rst_req),
        .rst_out_n  (rst_out_n),
        .rst_done   (rst_done),
        .state      (state),
        .cycle_cnt  (cycle_cnt)
    );

    reset_sequencer #(
        .SYNC_STAGES (3),
        .HOLD_CYCLES (1)
    ) u_short (
        .clk        (clk),
        .arst       (arst),
        .sw_rst_req (1'b0),
        .rst_out_n  (rst2_n),
        .rst_done   (done2),
        .state      (state2),
        .cycle_cnt  (cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and park on the following falling edge for sampling.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_rstn"},  32'(rst_out_n), 32'd0);
        chk({tag, "_done"},  32'(rst_done), 32'd0);
        chk({tag, "_cnt"},   32'(cycle_cnt), 32'd0);
    endtask

    // Release arst at a falling edge and check the 19-edge default sequence.
    task automatic release_seq(input string tag);
        arst = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 2) chk({tag, "_e2_state"}, 32'(state), 32'd0);
            if (k == 3) chk({tag, "_e3_state"}, 32'(state), 32'd1);
            if (k == 3) chk({tag, "_e3_cnt"}, 32'(cycle_cnt), 32'd0);
            if (k == 18) chk({tag, "_e18_rstn"}, 32'(rst_out_n), 32'd0);
            if (k == 19) chk({tag, "_e19_rstn"}, 32'(rst_out_n), 32'd1);
            if (k == 19) chk({tag, "_e19_state"}, 32'(state), 32'd2);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        arst       = 1'b0;
        sw_rst_req = 1'b0;
        repeat (5) @(negedge clk);
        chk_reset("por");
        chk("por_short_rstn", 32'(rst2_n), 32'd0);
        chk("por_short_state", 32'(state2), 32'd0);

        // Power-on with a software request pulsed during HOLD (must be ignored).
        arst = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            if (k == 8) sw_rst_req = 1'b1;
            if (k == 9) sw_rst_req = 1'b0;
            tick();
            if (k <= 2) begin
                chk("pwr_assert_state", 32'(state), 32'd0);
                chk("pwr_assert_rstn", 32'(rst_out_n), 32'd0);
            end else if (k <= 18) begin
                chk("pwr_hold_state", 32'(state), 32'd1);
                chk("pwr_hold_cnt", 32'(cycle_cnt), 32'(k - 3));
                chk("pwr_hold_rstn", 32'(rst_out_n), 32'd0);
                chk("pwr_hold_done", 32'(rst_done), 32'd0);
            end else begin
                chk("pwr_run_state", 32'(state), 32'd2);
                chk("pwr_run_rstn", 32'(rst_out_n), 32'd1);
                chk("pwr_run_done", 32'(rst_done), 32'd1);
                chk("pwr_run_cnt", 32'(cycle_cnt), 32'd0);
            end
            if (k == 3) chk("short_e3_state", 32'(state2), 32'd0);
            if (k == 4) chk("short_e4_state", 32'(state2), 32'd1);
            if (k == 4) chk("short_e4_rstn", 32'(rst2_n), 32'd0);
            if (k == 5) chk("short_e5_state", 32'(state2), 32'd2);
            if (k == 5) chk("short_e5_rstn", 32'(rst2_n), 32'd1);
            if (k == 5) chk("short_e5_done", 32'(done2), 32'd1);
        end

        // Single-cycle software reset request.
        tick();
        tick();
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        chk("sw_start_state", 32'(state), 32'd3);
        chk("sw_start_rstn", 32'(rst_out_n), 32'd0);
        chk("sw_start_done", 32'(rst_done), 32'd0);
        chk("sw_start_cnt", 32'(cycle_cnt), 32'd0);
        for (int j = 2; j <= 8; j++) begin
            tick();
            chk("sw_pulse_state", 32'(state), 32'd3);
            chk("sw_pulse_cnt", 32'(cycle_cnt), 32'(j - 1));
            chk("sw_pulse_rstn", 32'(rst_out_n), 32'd0);
            chk("sw_pulse_done", 32'(rst_done), 32'd0);
        end
        tick();
        chk("sw_end_state", 32'(state), 32'd2);
        chk("sw_end_rstn", 32'(rst_out_n), 32'd1);
        chk("sw_end_done", 32'(rst_done), 32'd1);

        // Held request: 8 low, 1 high, repeating.
        sw_rst_req = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            tick();
            chk("held_rstn", 32'(rst_out_n), (j % 9 == 0) ? 32'd1 : 32'd0);
            chk("held_state", 32'(state), (j % 9 == 0) ? 32'd2 : 32'd3);
        end
        sw_rst_req = 1'b0;
        repeat (4) tick();
        chk("held_tail_state", 32'(state), 32'd3);
        tick();
        chk("held_exit_state", 32'(state), 32'd2);
        chk("held_exit_rstn", 32'(rst_out_n), 32'd1);
        tick();
        chk("held_idle_state", 32'(state), 32'd2);

        // arst dropped mid-HOLD, away from any clock edge.
        arst = 1'b0;
        #1;
        chk_reset("drop_run");
        @(negedge clk);
        arst = 1'b1;
        repeat (10) tick();
        chk("midhold_state", 32'(state), 32'd1);
        chk("midhold_cnt", 32'(cycle_cnt), 32'd7);
        #2 arst = 1'b0;
        #1;
        chk_reset("drop_hold");
        @(negedge clk);
        release_seq("rel_hold");

        // arst dropped mid-SWRST.
        tick();
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        tick();
        tick();
        chk("midsw_state", 32'(state), 32'd3);
        chk("midsw_cnt", 32'(cycle_cnt), 32'd2);
        #2 arst = 1'b0;
        #1;
        chk_reset("drop_sw");
        @(negedge clk);
        release_seq("rel_sw");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
